// File: rtl/pet_spi_pkg.sv
// Shared types and widths for the SPI bus initiator and the bus-side targets.
package pet_spi_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    OP_WRITE = 3'b001,
    OP_READ  = 3'b010
  } spi_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrHi,
    StAddrLo,
    StWrData,
    StRdTurn,
    StRdData,
    StIgnore
  } spi_state_t;

endpackage

// File: rtl/spi_bus_initiator_if.sv
// SPI pins plus the bus strobe/address/data signals of the initiator.
interface spi_bus_initiator_if;
  import pet_spi_pkg::*;

  logic              spi_cs_n_i;
  logic              spi_sck_i;
  logic              spi_sdi_i;
  logic              spi_sdo_o;
  logic [ADDR_W-1:0] spi_addr_o;
  logic [DATA_W-1:0] spi_data_o;
  logic              spi_wr_en_o;
  logic              spi_rd_en_o;
  logic [DATA_W-1:0] spi_rd_data_i;

  // Initiator side: takes the SPI pins, drives the bus.
  modport master (
    input  spi_cs_n_i, spi_sck_i, spi_sdi_i, spi_rd_data_i,
    output spi_sdo_o, spi_addr_o, spi_data_o, spi_wr_en_o, spi_rd_en_o
  );

  // Environment side: MCU pins and bus targets.
  modport slave (
    output spi_cs_n_i, spi_sck_i, spi_sdi_i, spi_rd_data_i,
    input  spi_sdo_o, spi_addr_o, spi_data_o, spi_wr_en_o, spi_rd_en_o
  );

endinterface

// File: rtl/spi_bus_initiator_sync_bit.sv
// Flop-chain synchronizer for one asynchronous input bit.
module spi_bus_initiator_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the input down the chain; clears to 0 so a CS_N held low across reset
  // is never mistaken for a fresh falling edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bus_initiator.sv
// SPI mode-0 target that turns host frames into single-cycle bus write/read strobes.
module spi_bus_initiator
  import pet_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LATENCY  = 1
) (
  input logic               clk_i,
  input logic               reset_i,
  spi_bus_initiator_if.master bus
);

  logic cs_s, sck_s, sdi_s;
  logic cs_q, sck_q;
  logic sck_rise, sck_fall, cs_fall, rd_capture;
  logic [DATA_W-1:0] byte_in;

  spi_state_t        state_q;
  logic [2:0]        op_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        shift_q;
  logic [DATA_W-1:0] so_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              first_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              sdo_q;
  logic [RD_LATENCY-1:0] rd_pipe_q;

  spi_bus_initiator_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(bus.spi_cs_n_i), .q_o(cs_s)
  );
  spi_bus_initiator_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(bus.spi_sck_i), .q_o(sck_s)
  );
  spi_bus_initiator_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(bus.spi_sdi_i), .q_o(sdi_s)
  );

  // Previous synchronized levels for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_q  <= 1'b0;
      sck_q <= 1'b0;
    end else begin
      cs_q  <= cs_s;
      sck_q <= sck_s;
    end
  end

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_fall  = cs_q & ~cs_s;
  assign byte_in  = {shift_q, sdi_s};

  // Read strobe delay line; the tap marks the cycle the bus data is valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rd_capture = rd_pipe_q[RD_LATENCY-1] &&
                      (state_q == StRdTurn || state_q == StRdData);

  // Frame FSM with registered strobes, address, data and SDO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      so_q      <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      first_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;

      // Returned data reloads the shifter; bits leave MSB first on each SCK fall.
      if (rd_capture) begin
        so_q <= bus.spi_rd_data_i;
      end else if (sck_fall && state_q == StRdData && !cs_s) begin
        so_q <= {so_q[DATA_W-2:0], 1'b0};
      end

      if (cs_s) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        sdo_q     <= 1'b0;
      end else begin
        if (sck_fall) sdo_q <= (state_q == StRdData) ? so_q[DATA_W-1] : 1'b0;

        if (state_q == StIdle) begin
          if (cs_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= '0;
          end
        end else if (sck_rise) begin
          shift_q   <= byte_in[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            unique case (state_q)
              StCmd: begin
                op_q       <= byte_in[7:5];
                addr_q[16] <= byte_in[0];
                state_q    <= StAddrHi;
              end
              StAddrHi: begin
                addr_q[15:8] <= byte_in;
                state_q      <= StAddrLo;
              end
              StAddrLo: begin
                addr_q[7:0] <= byte_in;
                first_q     <= 1'b1;
                if (op_q == OP_WRITE) begin
                  state_q <= StWrData;
                end else if (op_q == OP_READ) begin
                  rd_en_q <= 1'b1;
                  state_q <= StRdTurn;
                end else begin
                  state_q <= StIgnore;
                end
              end
              StWrData: begin
                data_q  <= byte_in;
                wr_en_q <= 1'b1;
                first_q <= 1'b0;
                if (!first_q) addr_q <= addr_q + 1'b1;
              end
              StRdTurn: state_q <= StRdData;
              StRdData: begin
                addr_q  <= addr_q + 1'b1;
                rd_en_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.spi_sdo_o   = sdo_q;
  assign bus.spi_addr_o  = addr_q;
  assign bus.spi_data_o  = data_q;
  assign bus.spi_wr_en_o = wr_en_q;
  assign bus.spi_rd_en_o = rd_en_q;

endmodule
